// File: rtl/step_sequencer.sv
// step_sequencer: owns the control unit's step counter and supervises
// run / pause / halt / fault sequencing. It also counts retired instructions.
module step_sequencer #(
  parameter int STEP_W      = 4,
  parameter int FETCH_STEPS = 5,
  parameter int MAX_STEP    = 12,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sc_inc,
  input  logic              sc_reset,
  input  logic              halt_req,
  input  logic              start,
  input  logic              resume,
  input  logic              single_mode,
  input  logic              step_req,
  input  logic              clear,
  output logic [STEP_W-1:0] step,
  output logic              fetch_phase,
  output logic              running,
  output logic              halted,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [2:0] {IDLE, RUN, PAUSE, HALTED, FAULT} state_t;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_WDOG  = 2'b01;
  localparam logic [1:0] FC_RSTF  = 2'b10;
  localparam logic [1:0] FC_HALTF = 2'b11;

  localparam logic [STEP_W-1:0] FETCH_L = STEP_W'(FETCH_STEPS);
  localparam logic [STEP_W:0]   MAX_L   = (STEP_W+1)'(MAX_STEP);

  state_t            state;
  logic [STEP_W:0]   step_nxt;

  // Step decode: the first FETCH_STEPS steps belong to instruction fetch.
  assign fetch_phase = (step < FETCH_L);
  // Widened by one bit so that the watchdog compare never wraps.
  assign step_nxt    = {1'b0, step} + 1'b1;

  // Sequencer FSM; step, status flags and counter all update with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      step        <= '0;
      running     <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          step <= '0;
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (halt_req && !fetch_phase) begin
            state   <= HALTED;
            running <= 1'b0;
            halted  <= 1'b1;
          end else if (halt_req) begin
            state      <= FAULT;
            running    <= 1'b0;
            fault      <= 1'b1;
            fault_code <= FC_HALTF;
          end else if (sc_reset && fetch_phase) begin
            state      <= FAULT;
            running    <= 1'b0;
            fault      <= 1'b1;
            fault_code <= FC_RSTF;
          end else if (sc_reset) begin
            step        <= '0;
            instr_count <= instr_count + 1'b1;
            if (single_mode) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end else if (sc_inc) begin
            // Watchdog: step keeps its pre-increment value when it trips.
            if (step_nxt == MAX_L) begin
              state      <= FAULT;
              running    <= 1'b0;
              fault      <= 1'b1;
              fault_code <= FC_WDOG;
            end else begin
              step <= step_nxt[STEP_W-1:0];
            end
          end
        end
        PAUSE: begin
          step <= '0;
          if (step_req || !single_mode) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        HALTED: begin
          // PC already advanced during fetch, so restart at step 0.
          if (resume) begin
            state   <= RUN;
            step    <= '0;
            halted  <= 1'b0;
            running <= 1'b1;
          end
        end
        FAULT: begin
          if (clear) begin
            state      <= IDLE;
            step       <= '0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
          end
        end
        default: begin
          state   <= IDLE;
          step    <= '0;
          running <= 1'b0;
          halted  <= 1'b0;
          fault   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer. A second instance with a 4-bit
// retirement counter shares the stimulus so that counter wrap is reachable quickly.
module tb_step_sequencer;

  logic clk, rst_n;
  logic sc_inc, sc_reset, halt_req, start, resume, single_mode, step_req, clear;

  logic [3:0]  step;
  logic        fetch_phase, running, halted, fault;
  logic [1:0]  fault_code;
  logic [15:0] instr_count;

  logic [3:0]  s_step;
  logic        s_fetch_phase, s_running, s_halted, s_fault;
  logic [1:0]  s_fault_code;
  logic [3:0]  s_instr_count;

  int errors = 0;
  int checks = 0;

  step_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .sc_inc(sc_inc), .sc_reset(sc_reset),
    .halt_req(halt_req), .start(start), .resume(resume),
    .single_mode(single_mode), .step_req(step_req), .clear(clear),
    .step(step), .fetch_phase(fetch_phase), .running(running),
    .halted(halted), .fault(fault), .fault_code(fault_code),
    .instr_count(instr_count)
  );

  step_sequencer #(.CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .sc_inc(sc_inc), .sc_reset(sc_reset),
    .halt_req(halt_req), .start(start), .resume(resume),
    .single_mode(single_mode), .step_req(step_req), .clear(clear),
    .step(s_step), .fetch_phase(s_fetch_phase), .running(s_running),
    .halted(s_halted), .fault(s_fault), .fault_code(s_fault_code),
    .instr_count(s_instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobes(input logic inc, input logic rst, input logic hlt);
    sc_inc = inc; sc_reset = rst; halt_req = hlt;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_step"},  32'(step), 32'd0);
    chk({tag, "_fetch"}, 32'(fetch_phase), 32'd1);
    chk({tag, "_run"},   32'(running), 32'd0);
    chk({tag, "_halt"},  32'(halted), 32'd0);
    chk({tag, "_flt"},   32'(fault), 32'd0);
    chk({tag, "_code"},  32'(fault_code), 32'd0);
    chk({tag, "_cnt"},   32'(instr_count), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    strobes(0, 0, 0);
    start = 0; resume = 0; single_mode = 0; step_req = 0; clear = 0;
    #3;
    chk_reset_vals("rst");
    cyc(2);
    rst_n = 1'b1;
    cyc();

    // IDLE ignores control strobes
    strobes(1, 0, 0); cyc(2); strobes(0, 0, 0);
    chk("idle_step", 32'(step), 32'd0);
    chk("idle_run",  32'(running), 32'd0);

    // start, then 7 increments, then sc_reset+sc_inc at step 7
    start = 1; cyc(); start = 0;
    chk("start_run", 32'(running), 32'd1);
    chk("start_step", 32'(step), 32'd0);
    strobes(1, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      cyc();
      chk("inc_step", 32'(step), 32'(i));
    end
    chk("fetch_lo_at7", 32'(fetch_phase), 32'd0);
    strobes(1, 1, 0); cyc(); strobes(0, 0, 0);
    chk("ret1_step", 32'(step), 32'd0);
    chk("ret1_cnt",  32'(instr_count), 32'd1);
    chk("ret1_run",  32'(running), 32'd1);

    // single-step mode: pause after retirement, strobes ignored
    single_mode = 1;
    strobes(1, 0, 0); cyc(7);
    chk("ss_step7", 32'(step), 32'd7);
    strobes(0, 1, 0); cyc();
    chk("pause_run", 32'(running), 32'd0);
    chk("pause_cnt", 32'(instr_count), 32'd2);
    strobes(1, 1, 1); cyc(10); strobes(0, 0, 0);
    chk("pause_step", 32'(step), 32'd0);
    chk("pause_run2", 32'(running), 32'd0);
    chk("pause_cnt2", 32'(instr_count), 32'd2);
    chk("pause_flt", 32'(fault), 32'd0);
    chk("pause_hlt", 32'(halted), 32'd0);
    step_req = 1; cyc(); step_req = 0;
    chk("stepreq_run", 32'(running), 32'd1);
    strobes(1, 0, 0); cyc(); strobes(0, 0, 0);
    chk("stepreq_inc", 32'(step), 32'd1);
    single_mode = 0;

    // halt_req + sc_reset at step 5 -> HALTED
    strobes(1, 0, 0); cyc(4);
    chk("pre_halt_step", 32'(step), 32'd5);
    strobes(0, 1, 1); cyc(); strobes(0, 0, 0);
    chk("halt_hlt",  32'(halted), 32'd1);
    chk("halt_step", 32'(step), 32'd5);
    chk("halt_cnt",  32'(instr_count), 32'd2);
    chk("halt_run",  32'(running), 32'd0);
    start = 1; strobes(1, 1, 0); cyc(2); start = 0; strobes(0, 0, 0);
    chk("halt_ign_step", 32'(step), 32'd5);
    chk("halt_ign_hlt",  32'(halted), 32'd1);
    resume = 1; cyc(); resume = 0;
    chk("resume_step", 32'(step), 32'd0);
    chk("resume_run",  32'(running), 32'd1);
    chk("resume_hlt",  32'(halted), 32'd0);

    // watchdog: continuous sc_inc without sc_reset
    strobes(1, 0, 0); cyc(11);
    chk("wd_pre_step", 32'(step), 32'd11);
    chk("wd_pre_flt",  32'(fault), 32'd0);
    cyc(5); strobes(0, 0, 0);
    chk("wd_flt",  32'(fault), 32'd1);
    chk("wd_code", 32'(fault_code), 32'd1);
    chk("wd_step", 32'(step), 32'd11);
    chk("wd_run",  32'(running), 32'd0);
    start = 1; resume = 1; cyc(); start = 0; resume = 0;
    chk("flt_sticky", 32'(fault), 32'd1);
    clear = 1; cyc(); clear = 0;
    chk("clr_step", 32'(step), 32'd0);
    chk("clr_code", 32'(fault_code), 32'd0);
    chk("clr_flt",  32'(fault), 32'd0);
    chk("clr_run",  32'(running), 32'd0);
    chk("clr_cnt",  32'(instr_count), 32'd2);

    // sc_reset during fetch (step 2)
    start = 1; cyc(); start = 0;
    strobes(1, 0, 0); cyc(2);
    strobes(0, 1, 0); cyc(); strobes(0, 0, 0);
    chk("rstf_code", 32'(fault_code), 32'd2);
    chk("rstf_step", 32'(step), 32'd2);
    chk("rstf_cnt",  32'(instr_count), 32'd2);
    clear = 1; cyc(); clear = 0;

    // halt_req during fetch (step 3), sc_reset alongside must not matter
    start = 1; cyc(); start = 0;
    strobes(1, 0, 0); cyc(3);
    strobes(0, 1, 1); cyc(); strobes(0, 0, 0);
    chk("hltf_code", 32'(fault_code), 32'd3);
    chk("hltf_step", 32'(step), 32'd3);
    chk("hltf_hlt",  32'(halted), 32'd0);
    clear = 1; cyc(); clear = 0;

    // retirements up to the 4-bit counter wrap point (count 2 -> 15 -> 16)
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 13; i++) begin
      strobes(1, 0, 0); cyc(5);
      strobes(0, 1, 0); cyc();
    end
    strobes(0, 0, 0);
    chk("cnt15_main",  32'(instr_count), 32'd15);
    chk("cnt15_small", 32'(s_instr_count), 32'd15);
    strobes(1, 0, 0); cyc(5);
    strobes(0, 1, 0); cyc(); strobes(0, 0, 0);
    chk("wrap_small", 32'(s_instr_count), 32'd0);
    chk("wrap_main",  32'(instr_count), 32'd16);

    // asynchronous reset mid-instruction at step 6
    strobes(1, 0, 0); cyc(6);
    chk("pre_arst_step", 32'(step), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    strobes(0, 0, 0);
    cyc();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
